// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write-only driver: FSM states, LCD register
// field positions and the clear/home command codes that need the long execution wait.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } lcd_state_t;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_REQ_BIT  = 11;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_DATA_LSB = 0;

  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME   = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_X = 8'h03;

  // Clear display and return home take ~1.64ms on the panel; everything else ~40us.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == LCD_CMD_HOME_X);
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that parks at zero; the zero flag tells the FSM the current
// phase has run its full length.
module lcd_cycle_timer #(
  parameter int CNT_W = 17
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_hd44780_driver.sv
// Turns LSU LCD register writes (one per REQ toggle) into timed HD44780 write cycles:
// RS/DATA setup, EN pulse, hold, then the command execution wait.
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 12,
  parameter int HOLD_CYC       = 2,
  parameter int EXEC_CYC       = 2000,
  parameter int CLEAR_EXEC_CYC = 82000,
  parameter int CNT_W          = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_busy,
  output logic        o_lcd_done
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_EXEC_CYC - 1);

  lcd_state_t       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             on_q, on_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;
  logic             req;
  logic             lcd_word_unused;

  assign lcd_word_unused = ^{i_lcd_word[30:12], i_lcd_word[10], i_lcd_word[8]};

  // A request is pending whenever software's toggle differs from the last one accepted.
  assign req = i_lcd_word[LCD_REQ_BIT] != ack_q;

  lcd_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    rs_d         = rs_q;
    en_d         = en_q;
    busy_d       = busy_q;
    ack_d        = ack_q;
    done_d       = 1'b0;
    on_d         = i_lcd_word[LCD_ON_BIT];
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          data_d       = i_lcd_word[LCD_DATA_LSB +: 8];
          rs_d         = i_lcd_word[LCD_RS_BIT];
          ack_d        = i_lcd_word[LCD_REQ_BIT];
          busy_d       = 1'b1;
          state_d      = SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = LD_SETUP;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          en_d         = 1'b1;
          state_d      = PULSE;
          tmr_load     = 1'b1;
          tmr_load_val = LD_EN;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          en_d         = 1'b0;
          state_d      = HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = LD_HOLD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d      = EXEC;
          tmr_load     = 1'b1;
          tmr_load_val = is_clear_home(rs_q, data_q) ? LD_CLEAR : LD_EXEC;
        end
      end
      EXEC: begin
        if (tmr_zero) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      on_q    <= on_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_busy = busy_q;
  assign o_lcd_done = done_q;

endmodule
